// File: rtl/sample_accumulator.sv
// Streaming frame accumulator: sums a programmable number of valid samples
// into a full-precision result, emitting one strobed sum per frame.
module sample_accumulator #(
  parameter int DATA_W = 20,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [CNT_W-1:0]          num_minus1,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      sum_valid,
  output logic [DATA_W+CNT_W-1:0]   sum_data,
  output logic                      frame_active
);

  localparam int SUM_W = DATA_W + CNT_W;

  function automatic logic signed [SUM_W-1:0] ext_sample(input logic [DATA_W-1:0] d);
    if (SIGNED != 0) return {{CNT_W{d[DATA_W-1]}}, d};
    else             return {{CNT_W{1'b0}}, d};
  endfunction

  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        r_len;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    r_active;
  logic                    w_accept;
  logic                    w_first;
  logic                    w_last;

  logic                    r_vld_p1;
  logic                    r_first_p1;
  logic                    r_last_p1;
  logic signed [SUM_W-1:0] r_data_p1;

  logic                    r_done_p2;
  logic signed [SUM_W-1:0] r_acc_p2;

  logic                    r_vld_p3;
  logic [SUM_W-1:0]        r_sum_p3;

  assign w_accept = in_valid & ~clear;
  assign w_first  = (r_count == '0);
  // The first sample cannot use r_len yet: it is latched on this very edge.
  assign w_last   = w_first ? (num_minus1 == '0) : (r_count == r_len);

  always_comb begin
    w_count_nxt = r_count;
    if (clear)
      w_count_nxt = '0;
    else if (in_valid)
      w_count_nxt = w_last ? '0 : r_count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_len    <= '0;
      r_active <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_active <= (w_count_nxt != '0);
      if (w_accept && w_first)
        r_len <= num_minus1;
    end
  end

  // ---- S1: input register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_first_p1 <= 1'b0;
      r_last_p1  <= 1'b0;
      r_data_p1  <= '0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_first_p1 <= w_first;
        r_last_p1  <= w_last;
        r_data_p1  <= ext_sample(in_data);
      end
    end
  end

  // ---- S2: accumulator ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_p2 <= 1'b0;
      r_acc_p2  <= '0;
    end else begin
      r_done_p2 <= r_vld_p1 & r_last_p1 & ~clear;
      if (r_vld_p1)
        r_acc_p2 <= r_first_p1 ? r_data_p1 : r_acc_p2 + r_data_p1;
    end
  end

  // ---- S3: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p3 <= 1'b0;
      r_sum_p3 <= '0;
    end else begin
      r_vld_p3 <= r_done_p2;
      if (r_done_p2)
        r_sum_p3 <= r_acc_p2;
    end
  end

  assign sum_valid    = r_vld_p3;
  assign sum_data     = r_sum_p3;
  assign frame_active = r_active;

endmodule

// File: tb/tb_sample_accumulator.sv
// Bench for sample_accumulator: unsigned and signed instances share stimulus
// and are compared every cycle against a frame-level reference model.
module tb_sample_accumulator;

  localparam int DATA_W = 20;
  localparam int CNT_W  = 8;
  localparam int SUM_W  = DATA_W + CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic [CNT_W-1:0]  num_minus1 = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;

  logic              u_vld, s_vld, u_act, s_act;
  logic [SUM_W-1:0]  u_sum, s_sum;

  always #5 clk = ~clk;

  sample_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .num_minus1(num_minus1),
    .in_valid(in_valid), .in_data(in_data),
    .sum_valid(u_vld), .sum_data(u_sum), .frame_active(u_act));

  sample_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .clear(clear), .num_minus1(num_minus1),
    .in_valid(in_valid), .in_data(in_data),
    .sum_valid(s_vld), .sum_data(s_sum), .frame_active(s_act));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int               due;
    logic [SUM_W-1:0] u;
    logic [SUM_W-1:0] s;
  } pend_t;

  pend_t            pq[$];
  int               m_cnt = 0;
  int               m_len = 0;
  longint           m_u = 0;
  longint           m_s = 0;
  logic             exp_vld = 1'b0;
  logic             exp_act = 1'b0;
  logic [SUM_W-1:0] exp_u = '0;
  logic [SUM_W-1:0] exp_s = '0;

  // Drive one clock of stimulus, advance the frame model, sample after the edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic c);
    pend_t p;
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    cyc++;
    exp_vld = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      exp_vld = 1'b1;
      exp_u   = pq[0].u;
      exp_s   = pq[0].s;
      void'(pq.pop_front());
    end
    if (c) begin
      m_cnt = 0;
      if (pq.size() > 0 && pq[$].due == cyc + 1) void'(pq.pop_back());
    end else if (v) begin
      if (m_cnt == 0) begin
        m_len = int'(num_minus1);
        m_u = 0;
        m_s = 0;
      end
      m_u += longint'(d);
      m_s += longint'($signed(d));
      if (m_cnt == m_len) begin
        p.due = cyc + 2;
        p.u   = m_u[SUM_W-1:0];
        p.s   = m_s[SUM_W-1:0];
        pq.push_back(p);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    exp_act = (m_cnt != 0);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got vld=%b act=%b u=%h s=%h need all zero", u_vld, u_act, u_sum, s_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, 1'b0);
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
  endtask

  task automatic test_basic();
    int vals[8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    int strobe_cyc = -1;
    int last_cyc = 0;
    num_minus1 = 8'd3;
    for (int i = 0; i < 8; i++) begin
      step(i < 4, DATA_W'(vals[i]), 1'b0);
      if (i == 3) last_cyc = cyc;
      if (u_vld) strobe_cyc = cyc;
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
    n_chk++;
    if (u_sum !== 28'd10 || u_act !== 1'b0 || strobe_cyc != last_cyc + 2) begin
      n_fail++;
      $display("FAIL basic_sum got sum=%h act=%b strobe_at=%0d need sum=%h act=0 strobe_at=%0d",
               u_sum, u_act, strobe_cyc, 28'd10, last_cyc + 2);
    end
  endtask

  task automatic test_full();
    num_minus1 = 8'hFF;
    for (int i = 0; i < 260; i++) begin
      step(i < 256, 20'hFFFFF, 1'b0);
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL full cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
    n_chk++;
    if (u_sum !== 28'h0FFFFF00) begin
      n_fail++;
      $display("FAIL full_unsigned got %h need %h", u_sum, 28'h0FFFFF00);
    end
    num_minus1 = 8'd1;
    for (int i = 0; i < 4; i++) begin
      step(i < 2, (i == 0) ? 20'hFFFFF : 20'hFFFFE, 1'b0);
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL signed cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
    n_chk++;
    if (s_sum !== 28'hFFFFFFD) begin
      n_fail++;
      $display("FAIL signed_sum got %h need %h", s_sum, 28'hFFFFFFD);
    end
  endtask

  task automatic test_gaps();
    int v_tab[10] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    int d_tab[10] = '{5, 0, 0, 0, 7, 1, 1, 0, 0, 0};
    int sc[$];
    logic [SUM_W-1:0] ss[$];
    num_minus1 = 8'd1;
    for (int i = 0; i < 10; i++) begin
      step(v_tab[i] != 0, DATA_W'(d_tab[i]), 1'b0);
      if (u_vld) begin
        sc.push_back(cyc);
        ss.push_back(u_sum);
      end
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL gaps cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
    n_chk++;
    if (sc.size() != 2 || ss[0] !== 28'd12 || ss[1] !== 28'd2 || sc[1] - sc[0] != 2) begin
      n_fail++;
      $display("FAIL gaps_frames got strobes=%0d need 2 strobes 2 apart with sums 12 then 2", sc.size());
    end
  endtask

  task automatic test_len1();
    int sc[$];
    logic [SUM_W-1:0] ss[$];
    num_minus1 = 8'd0;
    for (int i = 0; i < 6; i++) begin
      step(i < 3, DATA_W'(i + 1), 1'b0);
      if (u_vld) begin
        sc.push_back(cyc);
        ss.push_back(u_sum);
      end
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL len1 cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
    n_chk++;
    if (sc.size() != 3 || sc[2] - sc[0] != 2 || ss[0] !== 28'd1 || ss[1] !== 28'd2 || ss[2] !== 28'd3) begin
      n_fail++;
      $display("FAIL len1_stream got strobes=%0d need 3 consecutive strobes with sums 1,2,3", sc.size());
    end
  endtask

  task automatic test_clear();
    int v_tab[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int d_tab[11] = '{9, 9, 9, 4, 4, 4, 4, 0, 0, 0, 0};
    int nstrobe = 0;
    num_minus1 = 8'd3;
    for (int i = 0; i < 11; i++) begin
      if (i == 4) num_minus1 = 8'd1;
      step(v_tab[i] != 0, DATA_W'(d_tab[i]), i == 2);
      if (u_vld) nstrobe++;
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL clear cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
    n_chk++;
    if (nstrobe != 1 || u_sum !== 28'd16) begin
      n_fail++;
      $display("FAIL clear_result got strobes=%0d sum=%h need strobes=1 sum=%h", nstrobe, u_sum, 28'd16);
    end
  endtask

  task automatic test_reset_mid();
    num_minus1 = 8'd3;
    step(1'b1, 20'd1, 1'b0);
    step(1'b1, 20'd1, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got vld=%b act=%b u=%h s=%h need all zero", u_vld, u_act, u_sum, s_sum);
    end
    pq.delete();
    m_cnt = 0;
    exp_vld = 1'b0;
    exp_act = 1'b0;
    exp_u = '0;
    exp_s = '0;
    @(posedge clk);
    cyc++;
    #3;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(i < 4, 20'd1, 1'b0);
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL post_reset cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
    n_chk++;
    if (u_sum !== 28'd4) begin
      n_fail++;
      $display("FAIL post_reset_sum got %h need %h", u_sum, 28'd4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) num_minus1 = CNT_W'($urandom_range(0, 6));
      step($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 40) == 0);
      n_chk++;
      if ({u_vld, u_act, u_sum, s_vld, s_act, s_sum} !== {exp_vld, exp_act, exp_u, exp_vld, exp_act, exp_s}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got vld=%b act=%b u=%h s=%h need vld=%b act=%b u=%h s=%h",
                 cyc, u_vld, u_act, u_sum, s_sum, exp_vld, exp_act, exp_u, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_gaps();
    test_len1();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_accumulator.md
# sample_accumulator

Parametrised, pipelined frame accumulator for the ADC acquisition path. It sums a run-time programmable number of consecutive valid samples (1 to 2^CNT_W) into a full-precision result without overflow. It emits one result per frame with a single-cycle valid strobe. It sits after the sample capture stage and before averaging/decimation and readout, replacing the fixed two-operand 20-bit adder with a streaming, multi-sample, signed/unsigned-capable block.

## Interface
Parameters:
- DATA_W, default 20: input sample width.
- CNT_W, default 8: frame-length counter width; maximum frame length is 2^CNT_W samples.
- SIGNED, default 0: 0 means samples are unsigned and zero-extended; 1 means two's complement, sign-extended.
- Derived (localparam, not overridable): SUM_W = DATA_W + CNT_W.

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- clear, in, 1: synchronous frame abort and pipeline flush.
- num_minus1, in, CNT_W: frame length minus 1.
- in_valid, in, 1: in_data is accepted on this edge. There is no backpressure; the block is always ready.
- in_data, in, DATA_W: sample.
- sum_valid, out, 1: one-cycle strobe marking sum_data as a completed frame.
- sum_data, out, SUM_W: frame sum. Holds its value until the next strobe.
- frame_active, out, 1: high while a frame is partially accumulated (sample count ≠ 0).

## Operation
- Pipeline stages:
  - S1: input register of in_valid, extended in_data, first flag, and last flag.
  - S2: accumulator.
  - S3: output register.
- Sample counter:
  - Counts accepted samples.
  - first = (count == 0).
  - last = (count == len_latched).
  - On an accepted last sample, the counter wraps to 0; otherwise it increments.
- num_minus1 is latched into len_latched when the first sample of a frame is accepted.
  - Changes mid-frame take effect from the next frame only.
  - For the first sample, compare against num_minus1 directly. This handles num_minus1 = 0, where the first sample is also the last.
- Accumulator update on S1 valid:
  - acc <= first ? ext(data) : acc + ext(data).
  - Arithmetic is SUM_W wide.
  - Extension is zero-extension or sign-extension per SIGNED.
  - Overflow is impossible by construction.
- Output register:
  - When S2 completes a last sample, sum_data <= acc on the following edge and sum_valid pulses high for one cycle.
  - sum_data is otherwise held.
- Back-to-back frames:
  - The first sample of frame n+1 may enter S2 on the same edge that S3 captures frame n.
  - No samples are lost and there are no idle cycles between frames.
- in_valid gaps may occur anywhere. Only valid samples are counted or summed.
- clear:
  - Sample counter goes to 0.
  - S1 and S2 valid/last flags are cleared, so no sum_valid is generated for the aborted partial frame.
  - acc is don't-care, because the next first sample overwrites it.
  - sum_data holds its last value.
  - If clear and in_valid occur on the same edge, clear wins and the sample is dropped.
  - A sum_valid already in S3 on that edge completes.
- rst, asynchronous mid-frame: all state returns to reset values immediately, and the partial frame is discarded.
- Reset values:
  - sum_valid = 0, sum_data = 0, frame_active = 0.
  - Counter, acc, len_latched, and all pipeline valids = 0.

## Timing
- Last sample of a frame accepted at edge k (in_valid = 1):
  - S1 at k.
  - acc holds the full sum at k+1.
  - sum_data/sum_valid update at k+2.
  - sum_valid is high for exactly one cycle, [k+2, k+3).
- Fixed latency of 2 clocks from acceptance of the last sample to the strobe. It is independent of frame length and gaps.
- Throughput: one sample per clock, sustained indefinitely, including num_minus1 = 0, where sum_valid is continuously high after the pipeline fills.
- frame_active is registered and tracks count ≠ 0 after each edge.
- Target 100 MHz: the only adder on the critical path is the single SUM_W adder in S2.

## Test plan
- Defaults, num_minus1 = 3, samples 1, 2, 3, 4 back-to-back → one sum_valid pulse 2 clocks after sample 4, sum_data = 10, frame_active low afterwards.
- num_minus1 = 255, 256 samples of 20'hFFFFF, unsigned → sum_data = 28'h0FFFFF00. Then SIGNED = 1 with num_minus1 = 1 and samples 20'hFFFFF, 20'hFFFFE → sum_data = 28'hFFFFFFD (−3).
- num_minus1 = 1, samples 5, 7 with 3 idle cycles between them, then frame 2 samples 1, 1 immediately back-to-back → sums 12 then 2, no lost samples, strobes separated by 2 clocks.
- num_minus1 = 0, continuous stream 1, 2, 3 → sum_valid high 3 consecutive cycles with sum_data 1, 2, 3.
- num_minus1 = 3: send 2 samples, assert clear simultaneously with the 3rd sample, then send 4, 4, 4, 4 → no strobe for the aborted frame, next sum = 16. Also change num_minus1 to 1 mid-frame → the current frame still uses 4 samples.
- Assert rst asynchronously mid-frame → outputs 0 immediately. After release, frame 1, 1, 1, 1 → sum 4.
